peak_level_tracker: RTL and testbench
=====================================

# peak_level_tracker

- Multi-channel, parametrised high-water-mark tracker.
- Per channel, records the largest level sampled since reset or clear.
- Two modes:
  - Sticky: the maximum level locks until cleared.
  - Decay: the peak steps down after a programmable hold time.
- Sits after the level quantisers; feeds the status/threshold logic with a registered peak per channel.

## Interface
- `LEVEL_W`, 2, level width in bits; max level = 2^LEVEL_W-1.
- `NUM_CH`, 2, number of independent channels.
- `HOLD_CYCLES`, 4, decay-mode cycles without a new peak before the peak decrements by 1; must be ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `din_valid`  in  NUM_CH  per-channel sample strobe.
- `din`  in  NUM_CH*LEVEL_W  packed levels; channel k at bits [k*LEVEL_W +: LEVEL_W].
- `clear`  in  1  synchronous clear of all channels.
- `mode`  in  1  0 = sticky, 1 = decay; sampled every cycle.
- `dout`  out  NUM_CH*LEVEL_W  registered peak per channel, same packing as `din`.
- `seen`  out  NUM_CH  channel has accepted at least one sample since reset/clear.
- `at_max`  out  NUM_CH  channel is in SAT.

## Operation
- **Reset.** While `rst_n`=0, every channel is IDLE: `dout`=0, `seen`=0, `at_max`=0, hold counter=0.
- **Clear.** `clear`=1 forces every channel to IDLE at the next edge. It overrides `din_valid`, and that cycle's sample is discarded.
- **IDLE.** On `din_valid` → peak=`din`, hold counter=0, `seen`=1. Next state:
  - SAT if `din`=max and `mode`=0;
  - TRACK otherwise.
- **TRACK.**
  - `din_valid` with `din` > peak: peak=`din`, hold counter=0.
  - `din_valid` with `din` = peak: peak unchanged, hold counter=0.
  - If the new peak = max and `mode`=0 → SAT.
  - Decay mode (`mode`=1) with no peak update that cycle:
    - hold counter increments;
    - when it reaches HOLD_CYCLES-1: peak ← peak-1 if peak>0, and the counter returns to 0;
    - at peak=0 the counter still wraps, and the peak stays 0.
  - Sticky mode: the hold counter stays 0.
- **SAT.** Peak stays at max and all samples are ignored.
  - `mode`→1 moves the channel to TRACK with hold counter=0; decay starts the following cycle.
- **Mode change.** A 1→0 change in TRACK freezes decay immediately; the current peak is kept.
- **Arithmetic.** Unsigned comparison. The decrement never underflows, and the hold counter is $clog2(HOLD_CYCLES) bits wide, minimum 1.
- **Channels.** All channels are independent except for the shared `clear` and `mode`.

## Timing
- All outputs are registered.
- A sample taken at edge N is visible on `dout`, `seen` and `at_max` after edge N.
- Decay step: with no qualifying sample after the update edge, the peak drops exactly HOLD_CYCLES edges later, then every HOLD_CYCLES edges until it reaches 0.
- Asserting `rst_n` low clears the outputs immediately, with no clock needed. Reset mid-decay or in SAT returns the channel to IDLE.
- Deassert `rst_n` synchronously to `clk` (done upstream).
- No combinational path from inputs to outputs.

## Structure
- Shared package `peak_pkg`:
  - state typedef (IDLE=2'b00, TRACK=2'b01, SAT=2'b10);
  - mode constants `MODE_STICKY`=1'b0, `MODE_DECAY`=1'b1.
- Sub-module `peak_track_ch`: one channel, holding the FSM, peak register and hold counter, with parameters LEVEL_W and HOLD_CYCLES.
- The top instantiates NUM_CH copies in a generate loop and does the packing/unpacking only.

## Test plan
Bench parameters: LEVEL_W=2, NUM_CH=2, HOLD_CYCLES=4.
- **Reset.** `rst_n` low between edges → `dout`=0, `seen`=2'b00, `at_max`=2'b00 immediately. Release, no valids → unchanged.
- **Sticky tracking.** mode=0; ch0 valid samples 0,1,0,2,1,3,0 on consecutive edges → ch0 `dout` 0,1,1,2,2,3,3. `at_max`[0] rises after the sample 3 and stays.
- **Decay.** mode=1; ch0 single sample 3 at edge N, then no valids → `dout`=3 through edge N+3, 2 at N+4, 1 at N+8, 0 at N+12, 0 thereafter. A sample 2 at N+6 (peak=2, equal) restarts the hold, so the peak drops to 1 at N+10.
- **Clear vs sample.** Peak ch0=2; `clear`=1 with `din_valid`[0]=1, `din`=3 on the same edge → next cycle `dout`=0, `seen`[0]=0.
- **Channel independence / SAT exit.** ch0←3, ch1←1 in sticky mode → `dout`={2'b01,2'b11}, `at_max`=2'b01. Switch mode=1 → ch0 leaves SAT, drops to 2 after 4 edges of decay; ch1 drops to 0 after 4 edges.
- **Async reset mid-operation.** Reset pulse during a decay countdown → all outputs 0 at once. After release, the first sample 1 gives `dout`=1, `seen`=1, with no stale hold count.

Source files
------------

// File: rtl/peak_level_tracker_pkg.sv
// Shared types and constants for the peak level tracker.
//   peak_state_e : per-channel FSM state (IDLE / TRACK / SAT)
//   MODE_STICKY  : mode value that locks the peak at its maximum
//   MODE_DECAY   : mode value that lets the peak step down after a hold time
//   cnt_width()  : hold-counter width for a given hold time (never below 1)
package peak_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    SAT   = 2'b10
  } peak_state_e;

  localparam logic MODE_STICKY = 1'b0;
  localparam logic MODE_DECAY  = 1'b1;

  // $clog2 of 1 is 0; a counter still needs one bit to exist.
  function automatic int cnt_width(input int hold);
    return (hold <= 2) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/peak_level_tracker_ch.sv
// One channel of the peak tracker: FSM, peak register and hold counter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   din_valid   : sample strobe for this channel
//   din         : sampled level
//   clear       : synchronous return to IDLE (wins over din_valid)
//   mode        : MODE_STICKY / MODE_DECAY, sampled every cycle
//   dout        : registered peak
//   seen        : at least one sample accepted since reset/clear
//   at_max      : channel is saturated (sticky at full scale)
module peak_track_ch
  import peak_pkg::*;
#(
  parameter int LEVEL_W     = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din_valid,
  input  logic [LEVEL_W-1:0] din,
  input  logic               clear,
  input  logic               mode,
  output logic [LEVEL_W-1:0] dout,
  output logic               seen,
  output logic               at_max
);

  localparam int                 CNT_W     = cnt_width(HOLD_CYCLES);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);

  peak_state_e        state_q, state_d;
  logic [LEVEL_W-1:0] peak_q,  peak_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  // A sample equal to the current peak refreshes the hold without changing it.
  logic upd;
  assign upd = din_valid && (din >= peak_q);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    peak_d  = peak_q;
    cnt_d   = cnt_q;

    if (clear) begin
      state_d = IDLE;
      peak_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (din_valid) begin
            peak_d  = din;
            cnt_d   = '0;
            state_d = (din == LEVEL_MAX && mode == MODE_STICKY) ? SAT : TRACK;
          end
        end

        TRACK: begin
          if (upd) begin
            peak_d = din;
            cnt_d  = '0;
          end else if (mode == MODE_DECAY) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
              // The counter keeps wrapping at zero; only the peak saturates.
              if (peak_q != '0) peak_d = peak_q - 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
          if (mode == MODE_STICKY && peak_d == LEVEL_MAX) state_d = SAT;
        end

        SAT: begin
          // Samples are ignored; leaving SAT restarts the hold from zero so
          // the first decay step lands a full hold time later.
          cnt_d = '0;
          if (mode == MODE_DECAY) state_d = TRACK;
        end

        default: begin
          state_d = IDLE;
          peak_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    if (!rst_n) begin
      state_q <= IDLE;
      peak_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      peak_q  <= peak_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registers only; no input reaches them combinationally.
  assign dout   = peak_q;
  assign seen   = (state_q != IDLE);
  assign at_max = (state_q == SAT);

endmodule

// File: rtl/peak_level_tracker.sv
// Multi-channel high-water-mark tracker with sticky and decay modes.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   din_valid   : per-channel sample strobe [NUM_CH]
//   din         : packed levels, channel k at [k*LEVEL_W +: LEVEL_W]
//   clear       : synchronous clear of every channel
//   mode        : 0 = sticky, 1 = decay (shared by all channels)
//   dout        : registered peak per channel, same packing as din
//   seen        : per-channel "sample accepted since reset/clear"
//   at_max      : per-channel saturated flag
module peak_level_tracker
  import peak_pkg::*;
#(
  parameter int LEVEL_W     = 2,
  parameter int NUM_CH      = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         din_valid,
  input  logic [NUM_CH*LEVEL_W-1:0] din,
  input  logic                      clear,
  input  logic                      mode,
  output logic [NUM_CH*LEVEL_W-1:0] dout,
  output logic [NUM_CH-1:0]         seen,
  output logic [NUM_CH-1:0]         at_max
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    peak_track_ch #(
      .LEVEL_W     (LEVEL_W),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .din_valid (din_valid[k]),
      .din       (din[k*LEVEL_W +: LEVEL_W]),
      .clear     (clear),
      .mode      (mode),
      .dout      (dout[k*LEVEL_W +: LEVEL_W]),
      .seen      (seen[k]),
      .at_max    (at_max[k])
    );
  end

endmodule

// File: tb/tb_peak_level_tracker.sv
// Self-checking bench for peak_level_tracker (LEVEL_W=2, NUM_CH=2, HOLD_CYCLES=4).
module tb_peak_level_tracker;
  import peak_pkg::*;

  localparam int LEVEL_W     = 2;
  localparam int NUM_CH      = 2;
  localparam int HOLD_CYCLES = 4;
  localparam int LMAX        = (1 << LEVEL_W) - 1;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic [NUM_CH-1:0]         din_valid = '0;
  logic [NUM_CH*LEVEL_W-1:0] din = '0;
  logic                      clear = 1'b0;
  logic                      mode = 1'b0;
  logic [NUM_CH*LEVEL_W-1:0] dout;
  logic [NUM_CH-1:0]         seen;
  logic [NUM_CH-1:0]         at_max;

  peak_level_tracker #(
    .LEVEL_W     (LEVEL_W),
    .NUM_CH      (NUM_CH),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_valid (din_valid),
    .din       (din),
    .clear     (clear),
    .mode      (mode),
    .dout      (dout),
    .seen      (seen),
    .at_max    (at_max)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel remembers its peak, whether it has seen a
  // sample, whether it is locked at full scale, and how many decay edges
  // have passed since the peak was last refreshed.
  int m_peak [NUM_CH];
  bit m_seen [NUM_CH];
  bit m_sat  [NUM_CH];
  int m_age  [NUM_CH];

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_peak[c] = 0; m_seen[c] = 0; m_sat[c] = 0; m_age[c] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      int lvl;
      lvl = int'(din[c*LEVEL_W +: LEVEL_W]);
      if (clear) begin
        m_peak[c] = 0; m_seen[c] = 0; m_sat[c] = 0; m_age[c] = 0;
      end else if (!m_seen[c]) begin
        if (din_valid[c]) begin
          m_peak[c] = lvl; m_seen[c] = 1; m_age[c] = 0;
          m_sat[c]  = (lvl == LMAX) && !mode;
        end
      end else if (m_sat[c]) begin
        if (mode) begin
          m_sat[c] = 0; m_age[c] = 0;
        end
      end else begin
        if (din_valid[c] && lvl >= m_peak[c]) begin
          m_peak[c] = lvl; m_age[c] = 0;
        end else if (mode) begin
          m_age[c] = m_age[c] + 1;
          if (m_age[c] >= HOLD_CYCLES) begin
            m_age[c] = 0;
            if (m_peak[c] > 0) m_peak[c] = m_peak[c] - 1;
          end
        end else begin
          m_age[c] = 0;
        end
        if (!mode && m_peak[c] == LMAX) m_sat[c] = 1;
      end
    end
  endfunction

  function automatic logic [NUM_CH*LEVEL_W-1:0] exp_dout();
    logic [NUM_CH*LEVEL_W-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c*LEVEL_W +: LEVEL_W] = LEVEL_W'(m_peak[c]);
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_seen();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = m_seen[c];
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_at_max();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = m_sat[c];
    return r;
  endfunction

  task automatic drive(input logic [NUM_CH-1:0] v, input logic [NUM_CH*LEVEL_W-1:0] d,
                       input logic m, input logic c);
    din_valid = v;
    din       = d;
    mode      = m;
    clear     = c;
  endtask

  // One clock edge: advance the model with the inputs the DUT saw, then
  // compare all outputs 1 time unit after the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check({tag, " dout"},   dout,   exp_dout());
    check({tag, " seen"},   seen,   exp_seen());
    check({tag, " at_max"}, at_max, exp_at_max());
  endtask

  task automatic do_clear(input logic m);
    drive('0, '0, m, 1'b1);
    tick("clear");
    drive('0, '0, m, 1'b0);
  endtask

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic [3:0] dout;
    logic [1:0] seen;
    logic [1:0] at_max;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b1, 2'd0, 4'd0, 2'b01, 2'b00};
    vecs[1] = '{1'b1, 2'd1, 4'd1, 2'b01, 2'b00};
    vecs[2] = '{1'b1, 2'd0, 4'd1, 2'b01, 2'b00};
    vecs[3] = '{1'b1, 2'd2, 4'd2, 2'b01, 2'b00};
    vecs[4] = '{1'b1, 2'd1, 4'd2, 2'b01, 2'b00};
    vecs[5] = '{1'b1, 2'd3, 4'd3, 2'b01, 2'b01};
    vecs[6] = '{1'b1, 2'd0, 4'd3, 2'b01, 2'b01};

    // Reset asserted between edges: outputs clear without a clock.
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("reset dout",   dout,   0);
    check("reset seen",   seen,   0);
    check("reset at_max", at_max, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick("idle");
    tick("idle");
    check("idle dout", dout, 0);
    check("idle seen", seen, 0);

    // Sticky tracking on ch0.
    for (int i = 0; i < 7; i++) begin
      drive({1'b0, vecs[i].v}, {2'b00, vecs[i].d}, MODE_STICKY, 1'b0);
      tick("sticky");
      check($sformatf("sticky[%0d] dout", i),   dout,   vecs[i].dout);
      check($sformatf("sticky[%0d] seen", i),   seen,   vecs[i].seen);
      check($sformatf("sticky[%0d] at_max", i), at_max, vecs[i].at_max);
    end
    drive('0, '0, MODE_STICKY, 1'b0);
    repeat (2) tick("sticky hold");
    check("sticky hold at_max", at_max, 2'b01);

    // Decay from 3 with no further samples.
    do_clear(MODE_DECAY);
    for (int off = 0; off <= 14; off++) begin
      int e;
      drive({1'b0, off == 0}, 4'b0011, MODE_DECAY, 1'b0);
      tick("decay");
      e = (off < 4) ? 3 : (off < 8) ? 2 : (off < 12) ? 1 : 0;
      check($sformatf("decay N+%0d", off), dout[1:0], e);
    end

    // Equal sample at N+6 restarts the hold.
    do_clear(MODE_DECAY);
    for (int off = 0; off <= 11; off++) begin
      int e;
      if (off == 0)      drive(2'b01, 4'b0011, MODE_DECAY, 1'b0);
      else if (off == 6) drive(2'b01, 4'b0010, MODE_DECAY, 1'b0);
      else               drive(2'b00, 4'b0000, MODE_DECAY, 1'b0);
      tick("restart");
      e = (off < 4) ? 3 : (off < 10) ? 2 : 1;
      check($sformatf("restart N+%0d", off), dout[1:0], e);
    end

    // Clear beats a same-edge sample.
    do_clear(MODE_STICKY);
    drive(2'b01, 4'b0010, MODE_STICKY, 1'b0);
    tick("clr pre");
    check("clr pre dout", dout[1:0], 2);
    drive(2'b01, 4'b0011, MODE_STICKY, 1'b1);
    tick("clr same");
    check("clr same dout", dout[1:0], 0);
    check("clr same seen", seen[0], 0);
    drive('0, '0, MODE_STICKY, 1'b0);
    tick("clr after");

    // Channel independence and SAT exit.
    do_clear(MODE_STICKY);
    drive(2'b11, 4'b0111, MODE_STICKY, 1'b0);
    tick("indep");
    check("indep dout",   dout,   4'b0111);
    check("indep at_max", at_max, 2'b01);
    for (int e = 0; e <= 4; e++) begin
      drive('0, '0, MODE_DECAY, 1'b0);
      tick("satexit");
      check($sformatf("satexit ch0 M+%0d", e), dout[1:0], (e < 4) ? 2'd3 : 2'd2);
      check($sformatf("satexit ch1 M+%0d", e), dout[3:2], (e < 3) ? 2'd1 : 2'd0);
      check($sformatf("satexit at_max M+%0d", e), at_max, 2'b00);
    end

    // Async reset in the middle of a decay countdown.
    do_clear(MODE_DECAY);
    drive(2'b01, 4'b0011, MODE_DECAY, 1'b0);
    tick("pre rst");
    drive('0, '0, MODE_DECAY, 1'b0);
    repeat (2) tick("pre rst");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst dout",   dout,   0);
    check("midrst seen",   seen,   0);
    check("midrst at_max", at_max, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(2'b01, 4'b0001, MODE_DECAY, 1'b0);
    tick("post rst");
    check("post rst dout", dout[1:0], 1);
    check("post rst seen", seen[0], 1);
    drive('0, '0, MODE_DECAY, 1'b0);
    repeat (3) tick("post rst hold");
    check("post rst hold", dout[1:0], 1);
    tick("post rst drop");
    check("post rst drop", dout[1:0], 0);

    // Randomized traffic against the model.
    do_clear(MODE_STICKY);
    for (int i = 0; i < 800; i++) begin
      logic m;
      m = mode;
      if ($urandom_range(0, 15) == 0) m = ~m;
      drive(NUM_CH'($urandom), (NUM_CH*LEVEL_W)'($urandom), m,
            $urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) == 0) din_valid = '0;
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
